// File: rtl/lcd_mon_pkg.sv
// Shared definitions for the LCD bus monitor: FSM states, command opcode
// bits, DDRAM address map constants and the address-step helper.
package lcd_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EN_HI = 2'd1,
        EXEC  = 2'd2
    } mon_state_e;

    // Command opcodes: the highest set bit of the byte selects the command.
    localparam logic [7:0] CMD_DDRAM = 8'h80;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h01;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Next DDRAM address after a data write, following the two-line wrap.
    function automatic logic [6:0] next_addr(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE1_LAST)      nxt = LINE2_BASE;
            else if (addr == LINE2_LAST) nxt = LINE1_BASE;
            else                         nxt = addr + 7'd1;
        end else begin
            if (addr == LINE1_BASE)      nxt = LINE2_LAST;
            else if (addr == LINE2_BASE) nxt = LINE1_LAST;
            else                         nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_mon_sync.sv
// Bus front end: synchronizes EN/RS/RW/DATA, qualifies EN pulses by their
// minimum high time and captures RS/RW/DATA at the start of each strobe.
// strobe is high for the single EXEC cycle of a qualified EN pulse.
module lcd_mon_sync
    import lcd_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EN_MIN_HIGH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       lcd_en_i,
    input  logic       lcd_rs_i,
    input  logic       lcd_rw_i,
    input  logic [7:0] lcd_data_i,
    output logic       strobe,
    output logic       cap_rs,
    output logic       cap_rw,
    output logic [7:0] cap_data
);

    localparam int              CNT_W  = $clog2(EN_MIN_HIGH + 1);
    localparam logic [CNT_W-1:0] EN_MIN = CNT_W'(EN_MIN_HIGH);

    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]                  bus_s;
    logic                         en_s;
    mon_state_e                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q;

    // Synchronizer chain; all bus bits travel together.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], {lcd_en_i, lcd_rs_i, lcd_rw_i, lcd_data_i}};
    end

    assign bus_s = sync_q[SYNC_STAGES-1];
    assign en_s  = bus_s[10];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: qualify the EN high time, then one EXEC cycle.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_s) state_d = EN_HI;
            EN_HI:   if (!en_s) state_d = (cnt_q >= EN_MIN) ? EXEC : IDLE;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // High-time counter (saturating) and capture of RS/RW/DATA at strobe start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else if (state_q == IDLE && en_s) begin
            cnt_q    <= CNT_W'(1);
            cap_rs   <= bus_s[9];
            cap_rw   <= bus_s[8];
            cap_data <= bus_s[7:0];
        end else if (state_q == EN_HI && en_s && cnt_q != EN_MIN) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign strobe = (state_q == EXEC);

endmodule

// File: rtl/lcd_bus_monitor.sv
// HD44780-style LCD write-bus monitor: decodes commands and data writes seen
// on the bus and rebuilds the 16x2 screen image on mp_o.
// Optional busy-window checking is enabled by defining LCD_MON_BUSY_EN.
module lcd_bus_monitor
    import lcd_mon_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int EN_MIN_HIGH    = 4,
    parameter int CLEAR_BUSY_CYC = 82000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         lcd_en_i,
    input  logic         lcd_rs_i,
    input  logic         lcd_rw_i,
    input  logic [7:0]   lcd_data_i,
    output logic [255:0] mp_o,
    output logic [6:0]   ddram_addr_o,
    output logic         disp_on_o,
    output logic         frame_done_o,
    output logic         rd_err_o,
    output logic         overrun_o
);

    logic       strobe, cap_rs, cap_rw;
    logic [7:0] cap_data;
    logic       exec_ok;

    lcd_mon_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EN_MIN_HIGH (EN_MIN_HIGH)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .lcd_en_i   (lcd_en_i),
        .lcd_rs_i   (lcd_rs_i),
        .lcd_rw_i   (lcd_rw_i),
        .lcd_data_i (lcd_data_i),
        .strobe     (strobe),
        .cap_rs     (cap_rs),
        .cap_rw     (cap_rw),
        .cap_data   (cap_data)
    );

`ifdef LCD_MON_BUSY_EN
    localparam int BUSY_W = $clog2((CLEAR_BUSY_CYC > 2000 ? CLEAR_BUSY_CYC : 2000) + 1);

    logic [BUSY_W-1:0] busy_q;
    logic              overrun_q;
    logic              is_clear_home;

    assign exec_ok       = strobe && (busy_q == '0);
    assign is_clear_home = !cap_rs && !cap_rw && (cap_data[7:2] == 6'd0) && (cap_data[1:0] != 2'd0);

    // Busy window: reload on each executed strobe, flag strobes that arrive early.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (exec_ok)             busy_q <= is_clear_home ? BUSY_W'(CLEAR_BUSY_CYC) : BUSY_W'(2000);
            else if (busy_q != '0)   busy_q <= busy_q - 1'b1;
            if (strobe && !exec_ok)  overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
`else
    // Without the busy window the clear delay has no use; keep it referenced.
    logic unused_clear_busy;
    assign unused_clear_busy = ^CLEAR_BUSY_CYC;

    assign exec_ok   = strobe;
    assign overrun_o = 1'b0;
`endif

    logic [255:0] screen_q, screen_d;
    logic [6:0]   addr_q, addr_d;
    logic         inc_q, inc_d;
    logic         cgram_q, cgram_d;
    logic         disp_q, disp_d;
    logic         rd_err_q, rd_err_d;
    logic         char_wr;
    logic [4:0]   char_idx;

    // Visible DDRAM locations map to one of the 32 screen cells.
    always_comb begin
        char_wr  = 1'b0;
        char_idx = {1'b0, addr_q[3:0]};
        if (addr_q[6:4] == LINE1_BASE[6:4]) begin
            char_wr  = 1'b1;
            char_idx = {1'b0, addr_q[3:0]};
        end else if (addr_q[6:4] == LINE2_BASE[6:4]) begin
            char_wr  = 1'b1;
            char_idx = {1'b1, addr_q[3:0]};
        end
    end

    // Apply the captured command or data byte during EXEC.
    always_comb begin
        screen_d = screen_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        cgram_d  = cgram_q;
        disp_d   = disp_q;
        rd_err_d = rd_err_q;
        if (exec_ok) begin
            if (cap_rw) begin
                rd_err_d = 1'b1;
            end else if (cap_rs) begin
                if (!cgram_q) begin
                    for (int k = 0; k < 32; k++) begin
                        if (char_wr && char_idx == k[4:0]) screen_d[8*(31-k) +: 8] = cap_data;
                    end
                    addr_d = next_addr(addr_q, inc_q);
                end
            end else if ((cap_data & CMD_DDRAM) != 8'h00) begin
                addr_d  = cap_data[6:0];
                cgram_d = 1'b0;
            end else if ((cap_data & CMD_CGRAM) != 8'h00) begin
                cgram_d = 1'b1;
            end else if ((cap_data & (CMD_FUNC | CMD_SHIFT)) != 8'h00) begin
                // Function set and shift commands leave the screen model alone.
            end else if ((cap_data & CMD_DISP) != 8'h00) begin
                disp_d = cap_data[2];
            end else if ((cap_data & CMD_ENTRY) != 8'h00) begin
                inc_d = cap_data[1];
            end else if ((cap_data & CMD_HOME) != 8'h00) begin
                addr_d = LINE1_BASE;
            end else if ((cap_data & CMD_CLEAR) != 8'h00) begin
                screen_d = {32{SPACE_CHAR}};
                addr_d   = LINE1_BASE;
                inc_d    = 1'b1;
            end
        end
    end

    // Screen image and control registers.
    // NOTE: the screen cells are ordinary flops with a reset, since the image must read as spaces out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            screen_q <= {32{SPACE_CHAR}};
            addr_q   <= LINE1_BASE;
            inc_q    <= 1'b1;
            cgram_q  <= 1'b0;
            disp_q   <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            screen_q <= screen_d;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            cgram_q  <= cgram_d;
            disp_q   <= disp_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign mp_o         = screen_q;
    assign ddram_addr_o = addr_q;
    assign disp_on_o    = disp_q;
    assign rd_err_o     = rd_err_q;
    assign frame_done_o = exec_ok && cap_rs && !cap_rw && !cgram_q && (addr_q == 7'h4F);

endmodule
